// File: rtl/codec_sample_fifo.sv
// Frame FIFO between the sample generators and the ac97 codec interface.
// One frame is popped per new_frame rising edge and shown on that same cycle.
module codec_sample_fifo #(
    parameter int WIDTH         = 18,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 8,
    parameter int LOW_WATER     = 2,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS*WIDTH-1:0]     in_frame,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          new_frame,
    output logic [CHANNELS*WIDTH-1:0]     valid_sample,
    output logic                          frame_strobe,
    output logic                          low_water,
    output logic [$clog2(DEPTH+1)-1:0]    fill,
    input  logic                          clear_underrun,
    output logic [15:0]                   underrun_count
);

    localparam int FW = CHANNELS * WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [FW-1:0] frame_t;

    frame_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fill_q;
    frame_t          held_q;
    frame_t          pop_frame;
    logic            prev_new_frame;
    logic [15:0]     underrun_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            underrun;

    assign full     = (fill_q == CW'(DEPTH));
    assign empty    = (fill_q == '0);
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;

    // Gated by reset so a high new_frame cannot strobe while the block is held in reset.
    assign frame_strobe = new_frame & ~prev_new_frame & reset;
    assign pop          = frame_strobe & ~empty;
    assign underrun     = frame_strobe & empty;

    // NOTE: every variable gets a default first so this block can never infer a latch.
    always_comb begin
        pop_frame = held_q;
        if (pop)
            pop_frame = mem[rd_ptr];
        else if (underrun && (UNDERRUN_ZERO != 0))
            pop_frame = '0;
    end

    // Bypass: on a strobe the popped frame appears before the held register loads it.
    assign valid_sample   = pop_frame;
    assign fill           = fill_q;
    assign low_water      = (fill_q <= CW'(LOW_WATER));
    assign underrun_count = underrun_q;

    // NOTE: storage has no reset; slots are only read after being written, guarded by fill.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_frame;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_q         <= '0;
            held_q         <= '0;
            prev_new_frame <= 1'b0;
        end else begin
            prev_new_frame <= new_frame;
            if (frame_strobe)
                held_q <= pop_frame;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + CW'(1);
                2'b01:   fill_q <= fill_q - CW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Clear wins over a same-cycle underrun increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            underrun_q <= '0;
        else if (clear_underrun)
            underrun_q <= '0;
        else if (underrun && (underrun_q != 16'hFFFF))
            underrun_q <= underrun_q + 16'd1;
    end

endmodule
